product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter P_WIDTH, default 64, width of the incoming unsigned product.
REQ-002 SHALL have parameter GUARD_BITS, default 8, extra accumulator MSBs above P_WIDTH.
REQ-003 SHALL have parameter OUT_WIDTH, default 32, width of the scaled output sum.
REQ-004 SHALL have parameter SHIFT, default 32, right shift applied to the accumulator before output.
REQ-005 SHALL have parameter COUNT_WIDTH, default 16, width of the products-per-sum count.
REQ-006 SHALL have port clk, input, 1, the only clock; every register is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port count, input, COUNT_WIDTH, products per sum; value 0 is treated as 1.
REQ-009 SHALL have port clr, input, 1, synchronous abort of the sum in progress.
REQ-010 SHALL have port p, input, P_WIDTH, unsigned product from the upstream multiplier.
REQ-011 SHALL have port p_valid, input, 1, qualifies p in the same cycle.
REQ-012 SHALL have port sum, output, OUT_WIDTH, scaled and saturated sum.
REQ-013 SHALL have port sum_valid, output, 1, single-cycle strobe that qualifies sum.
REQ-014 SHALL have port sat, output, 1, asserted with sum_valid when the accumulator or the output saturated.

Function
REQ-015 SHALL have an accumulator acc of width P_WIDTH+GUARD_BITS, unsigned, and a down-counter rem of width COUNT_WIDTH.
REQ-016 SHALL implement two states: IDLE and ACCUM.
REQ-017 SHALL, in IDLE on p_valid: latch N = max(count,1), set acc = p, set rem = N-1; go to ACCUM if N>1, else stay in IDLE and flag the sum complete.
REQ-018 SHALL, in ACCUM on p_valid: set acc = acc + p and decrement rem; the sample that brings rem to 0 completes the sum and returns the block to IDLE.
REQ-019 SHALL sample count only at the first product of a sum; changes to count during ACCUM have no effect on the sum in progress.
REQ-020 SHALL saturate acc at all-ones on carry-out, hold it at all-ones, and set a sticky acc_ovf flag for the current sum.
REQ-021 SHALL, in the cycle after completion, register s = acc >> SHIFT (rounded per REQ-030); if s > 2^OUT_WIDTH-1, sum SHALL be all-ones.
REQ-022 SHALL give a latency of 2 cycles: a completing p_valid at edge k produces sum_valid high for exactly the cycle following edge k+2.
REQ-023 SHALL hold sum stable between strobes, and drive sat = acc_ovf OR output saturation for that sum.
REQ-024 SHALL accept back-to-back sums: a p_valid in the cycle right after completion starts a new sum without loss, and the output pipeline stays independent of it.
REQ-025 SHALL, on clr, discard the current sum, clear acc_ovf and enter IDLE; clr has priority over a simultaneous p_valid, which is dropped; a completion already in the output stage still emits.
REQ-026 SHALL ignore p while p_valid is low; gaps of any length within a sum are allowed.

Reset
REQ-027 SHALL, on rst_n low, asynchronously force: state IDLE, acc 0, rem 0, acc_ovf 0, sum 0, sum_valid 0, sat 0.
REQ-028 SHALL, on a reset asserted mid-sum, abandon that sum with no sum_valid emitted; the first p_valid after release starts a new sum.
REQ-029 SHALL release reset on the clock edge after deassertion is synchronised externally; the block needs no internal synchroniser.

Configuration
REQ-030 SHALL, with PRODUCT_ACCUMULATOR_ROUND_EN defined, compute s = (acc + 2^(SHIFT-1)) >> SHIFT (round half up, saturating add); without it, s = acc >> SHIFT (truncate). With SHIFT=0, rounding is a no-op.

Verification
REQ-031 SHALL cover: count=4, SHIFT=0, p=10,20,30,40 contiguous -> one sum_valid 2 cycles after the 4th product, sum=100, sat=0.
REQ-032 SHALL cover: count=0, p=7 then p=9 one cycle apart -> two strobes, sum=7 then 9, each 2 cycles after its product.
REQ-033 SHALL cover: SHIFT=32, count=2, p=2^31,2^31 -> with ROUND_EN sum=1; without ROUND_EN sum=1; p=2^31 with count=1 -> with ROUND_EN sum=1, without sum=0.
REQ-034 SHALL cover: P_WIDTH=8, GUARD_BITS=0, SHIFT=0, OUT_WIDTH=8, count=2, p=200,100 -> sum=255, sat=1.
REQ-035 SHALL cover: count=3, two products, then clr coincident with a third p_valid -> no strobe; next sum of 1,2,3 -> sum=6.
REQ-036 SHALL cover: rst_n pulsed low mid-sum (asynchronous, between edges) -> outputs zero immediately, no strobe; count=2 sum of 5,5 -> sum=10.

Source files
------------

// File: rtl/product_accumulator.sv
// Accumulates `count` unsigned products per sum, then shifts, saturates and strobes the result.
// Define PRODUCT_ACCUMULATOR_ROUND_EN for round-half-up before the shift (default: truncate).
module product_accumulator #(
  parameter int P_WIDTH     = 64,
  parameter int GUARD_BITS  = 8,
  parameter int OUT_WIDTH   = 32,
  parameter int SHIFT       = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic                   clr,
  input  logic [P_WIDTH-1:0]     p,
  input  logic                   p_valid,
  output logic [OUT_WIDTH-1:0]   sum,
  output logic                   sum_valid,
  output logic                   sat
);

  localparam int AW = P_WIDTH + GUARD_BITS;

  // Handshake: p is consumed on every rising edge where p_valid is high (no back-pressure);
  // sum/sat are meaningful on the single cycle where sum_valid is high and hold otherwise.

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t                 state;
  logic [AW-1:0]          acc;
  logic [COUNT_WIDTH-1:0] rem;
  logic                   acc_ovf;
  logic                   done;

  logic                   s1_valid;
  logic [OUT_WIDTH-1:0]   s1_sum;
  logic                   s1_sat;

  logic [COUNT_WIDTH-1:0] n_first;
  logic [AW:0]            acc_sum;
  logic                   carry;

  assign n_first = (count == '0) ? COUNT_WIDTH'(1) : count;
  assign acc_sum = {1'b0, acc} + (AW+1)'(p);
  assign carry   = acc_sum[AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      acc     <= '0;
      rem     <= '0;
      acc_ovf <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        state   <= S_IDLE;
        acc     <= '0;
        rem     <= '0;
        acc_ovf <= 1'b0;
      end else if (p_valid) begin
        case (state)
          S_IDLE: begin
            acc     <= AW'(p);
            acc_ovf <= 1'b0;
            rem     <= n_first - COUNT_WIDTH'(1);
            if (n_first == COUNT_WIDTH'(1)) done <= 1'b1;
            else                            state <= S_ACCUM;
          end
          S_ACCUM: begin
            // Once saturated the accumulator is pinned at all-ones for the rest of the sum.
            if (acc_ovf || carry) begin
              acc     <= '1;
              acc_ovf <= 1'b1;
            end else begin
              acc <= acc_sum[AW-1:0];
            end
            rem <= rem - COUNT_WIDTH'(1);
            if (rem == COUNT_WIDTH'(1)) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  logic [AW-1:0] acc_r;
`ifdef PRODUCT_ACCUMULATOR_ROUND_EN
  localparam logic [AW:0] RND_INC =
    (SHIFT > 0) ? ((AW+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  logic [AW:0] rnd_sum;
  assign rnd_sum = {1'b0, acc} + RND_INC;
  assign acc_r   = rnd_sum[AW] ? '1 : rnd_sum[AW-1:0];
`else
  assign acc_r = acc;
`endif

  logic [AW-1:0]        s_shift;
  logic                 out_ovf;
  logic [OUT_WIDTH-1:0] s_out;

  assign s_shift = acc_r >> SHIFT;
  assign out_ovf = |(s_shift >> OUT_WIDTH);
  assign s_out   = out_ovf ? '1 : OUT_WIDTH'(s_shift);

  // Two-stage output pipeline reads acc before a back-to-back sum overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_sat    <= 1'b0;
      sum       <= '0;
      sum_valid <= 1'b0;
      sat       <= 1'b0;
    end else begin
      s1_valid  <= done;
      sum_valid <= s1_valid;
      if (done) begin
        s1_sum <= s_out;
        s1_sat <= acc_ovf | out_ovf;
      end
      if (s1_valid) begin
        sum <= s1_sum;
        sat <= s1_sat;
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: three parameterisations, scoreboard queues with
// expected {strobe cycle, sat, sum}, monitors pop on sum_valid.
module tb_product_accumulator;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  // Instance a: SHIFT=0, 64-bit products
  logic [15:0] count_a;
  logic        clr_a;
  logic [63:0] p_a;
  logic        pv_a;
  logic [31:0] sum_a;
  logic        sv_a;
  logic        sat_a;

  // Instance b: default parameters (SHIFT=32)
  logic [15:0] count_b;
  logic        clr_b;
  logic [63:0] p_b;
  logic        pv_b;
  logic [31:0] sum_b;
  logic        sv_b;
  logic        sat_b;

  // Instance c: 8-bit, no guard bits
  logic [15:0] count_c;
  logic        clr_c;
  logic [7:0]  p_c;
  logic        pv_c;
  logic [7:0]  sum_c;
  logic        sv_c;
  logic        sat_c;

  logic [48:0] exp_a_q[$];
  logic [48:0] exp_b_q[$];
  logic [48:0] exp_c_q[$];

  product_accumulator #(.P_WIDTH(64), .GUARD_BITS(8), .OUT_WIDTH(32), .SHIFT(0), .COUNT_WIDTH(16)) u_a (
    .clk(clk), .rst_n(rst_n), .count(count_a), .clr(clr_a), .p(p_a), .p_valid(pv_a),
    .sum(sum_a), .sum_valid(sv_a), .sat(sat_a)
  );

  product_accumulator u_b (
    .clk(clk), .rst_n(rst_n), .count(count_b), .clr(clr_b), .p(p_b), .p_valid(pv_b),
    .sum(sum_b), .sum_valid(sv_b), .sat(sat_b)
  );

  product_accumulator #(.P_WIDTH(8), .GUARD_BITS(0), .OUT_WIDTH(8), .SHIFT(0), .COUNT_WIDTH(16)) u_c (
    .clk(clk), .rst_n(rst_n), .count(count_c), .clr(clr_c), .p(p_c), .p_valid(pv_c),
    .sum(sum_c), .sum_valid(sv_c), .sat(sat_c)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic chk_strobe(input string nm, input logic [31:0] got_sum, input logic got_sat,
                            input logic [48:0] e);
    chk({nm, "_sum"}, 64'(got_sum), 64'(e[31:0]));
    chk({nm, "_sat"}, 64'(got_sat), 64'(e[32]));
    chk({nm, "_cycle"}, 64'(cyc), 64'(e[48:33]));
  endtask

  task automatic extra_strobe(input string nm);
    checks++;
    failures++;
    $display("FAIL %s_unexpected_strobe got=strobe exp=none (cycle %0d)", nm, cyc);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [48:0] e;
    if (sv_a) begin
      if (exp_a_q.size() == 0) extra_strobe("a");
      else begin e = exp_a_q.pop_front(); chk_strobe("a", sum_a, sat_a, e); end
    end
    if (sv_b) begin
      if (exp_b_q.size() == 0) extra_strobe("b");
      else begin e = exp_b_q.pop_front(); chk_strobe("b", sum_b, sat_b, e); end
    end
    if (sv_c) begin
      if (exp_c_q.size() == 0) extra_strobe("c");
      else begin e = exp_c_q.pop_front(); chk_strobe("c", 32'(sum_c), sat_c, e); end
    end
  end

  // ---------------- driver tasks (entered at posedge + 1) ----------------
  task automatic send(input int inst, input logic [63:0] pv, input logic last,
                      input logic [31:0] es, input logic esat);
    logic [48:0] e;
    e = {16'(cyc + 3), esat, es};
    case (inst)
      0: begin p_a = pv;      pv_a = 1'b1; if (last) exp_a_q.push_back(e); end
      1: begin p_b = pv;      pv_b = 1'b1; if (last) exp_b_q.push_back(e); end
      default: begin p_c = pv[7:0]; pv_c = 1'b1; if (last) exp_c_q.push_back(e); end
    endcase
    @(posedge clk); #1;
    pv_a = 1'b0; pv_b = 1'b0; pv_c = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] exp_round1;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    count_a = '0; clr_a = 1'b0; p_a = '0; pv_a = 1'b0;
    count_b = '0; clr_b = 1'b0; p_b = '0; pv_b = 1'b0;
    count_c = '0; clr_c = 1'b0; p_c = '0; pv_c = 1'b0;
`ifdef PRODUCT_ACCUMULATOR_ROUND_EN
    exp_round1 = 32'd1;
`else
    exp_round1 = 32'd0;
`endif
    repeat (3) @(posedge clk);
    #2;
    chk("reset_sum_a", 64'(sum_a), 64'd0);
    chk("reset_valid_a", 64'(sv_a), 64'd0);
    chk("reset_sat_c", 64'(sat_c), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Four contiguous products, SHIFT=0
    count_a = 16'd4;
    send(0, 64'd10, 1'b0, 32'd0, 1'b0);
    send(0, 64'd20, 1'b0, 32'd0, 1'b0);
    send(0, 64'd30, 1'b0, 32'd0, 1'b0);
    send(0, 64'd40, 1'b1, 32'd100, 1'b0);
    idle(3);

    // count=0 behaves as 1; back-to-back single-product sums
    count_a = 16'd0;
    send(0, 64'd7, 1'b1, 32'd7, 1'b0);
    send(0, 64'd9, 1'b1, 32'd9, 1'b0);
    idle(4);

    // Gaps inside a sum
    count_a = 16'd3;
    send(0, 64'd1, 1'b0, 32'd0, 1'b0);
    idle(2);
    send(0, 64'd2, 1'b0, 32'd0, 1'b0);
    idle(1);
    send(0, 64'd4, 1'b1, 32'd7, 1'b0);
    idle(4);

    // clr coincident with the third product: sum dropped
    count_a = 16'd3;
    send(0, 64'd100, 1'b0, 32'd0, 1'b0);
    send(0, 64'd200, 1'b0, 32'd0, 1'b0);
    clr_a = 1'b1; p_a = 64'd300; pv_a = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0; pv_a = 1'b0;
    idle(4);

    // Next sum 1,2,3; count changed mid-sum must be ignored
    send(0, 64'd1, 1'b0, 32'd0, 1'b0);
    count_a = 16'd1;
    send(0, 64'd2, 1'b0, 32'd0, 1'b0);
    send(0, 64'd3, 1'b1, 32'd6, 1'b0);
    idle(4);

    // SHIFT=32 cases on the default instance
    count_b = 16'd2;
    send(1, 64'h8000_0000, 1'b0, 32'd0, 1'b0);
    send(1, 64'h8000_0000, 1'b1, 32'd1, 1'b0);
    count_b = 16'd1;
    send(1, 64'h8000_0000, 1'b1, exp_round1, 1'b0);
    count_b = 16'd2;
    send(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'd0, 1'b0);
    send(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
    idle(4);

    // Narrow instance: accumulator carry-out saturates, next sum clean
    count_c = 16'd2;
    send(2, 64'd200, 1'b0, 32'd0, 1'b0);
    send(2, 64'd100, 1'b1, 32'd255, 1'b1);
    send(2, 64'd100, 1'b0, 32'd0, 1'b0);
    send(2, 64'd55, 1'b1, 32'd155, 1'b0);
    idle(5);

    // Asynchronous reset mid-sum, between edges
    count_a = 16'd2;
    send(0, 64'd5, 1'b0, 32'd0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sum_a", 64'(sum_a), 64'd0);
    chk("async_rst_valid_a", 64'(sv_a), 64'd0);
    chk("async_rst_sat_c", 64'(sat_c), 64'd0);
    chk("async_rst_sum_b", 64'(sum_b), 64'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 64'd5, 1'b0, 32'd0, 1'b0);
    send(0, 64'd5, 1'b1, 32'd10, 1'b0);
    idle(8);

    chk("drain_a", 64'(exp_a_q.size()), 64'd0);
    chk("drain_b", 64'(exp_b_q.size()), 64'd0);
    chk("drain_c", 64'(exp_c_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
